// File: rtl/video_pkg.sv
// Shared definitions for the raster video source.
// Contents: pattern select codes, default raster timing, and width helpers
// used to size the h/v counters and the x/y position outputs.
package video_pkg;

  localparam logic [1:0] PAT_RAMP  = 2'd0;
  localparam logic [1:0] PAT_XGRAD = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_CONST = 2'd3;

  localparam int DEF_H_ACTIVE = 10;
  localparam int DEF_H_FP     = 2;
  localparam int DEF_H_SYNC   = 3;
  localparam int DEF_H_BP     = 1;
  localparam int DEF_V_ACTIVE = 5;
  localparam int DEF_V_FP     = 1;
  localparam int DEF_V_SYNC   = 1;
  localparam int DEF_V_BP     = 1;

  // Bits needed to hold values 0..n-1, never less than 1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int total4(input int a, input int fp, input int s, input int bp);
    return a + fp + s + bp;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Horizontal/vertical raster position counters.
// Ports:
//   i_clk, i_rst_n  pixel clock, async active-low reset
//   i_en            advance enable; low holds both counters
//   o_h_cnt         0..H_TOTAL-1
//   o_v_cnt         0..V_TOTAL-1, steps when o_h_cnt wraps
//   o_h_wrap        counter is on the last clock of a line
//   o_frame_wrap    counter is on the last clock of a frame
module raster_counter
  import video_pkg::*;
#(
  parameter int H_TOTAL = 16,
  parameter int V_TOTAL = 8,
  parameter int HW      = cnt_w(H_TOTAL + 1),
  parameter int VW      = cnt_w(V_TOTAL + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_en,
  output logic [HW-1:0] o_h_cnt,
  output logic [VW-1:0] o_v_cnt,
  output logic          o_h_wrap,
  output logic          o_frame_wrap
);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;

  assign o_h_cnt      = r_h;
  assign o_v_cnt      = r_v;
  assign o_h_wrap     = (r_h == H_LAST);
  assign o_frame_wrap = o_h_wrap && (r_v == V_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_h <= '0;
      r_v <= '0;
    end else if (i_en) begin
      if (o_h_wrap) begin
        r_h <= '0;
        r_v <= o_frame_wrap ? '0 : r_v + VW'(1);
      end else begin
        r_h <= r_h + HW'(1);
      end
    end
  end

endmodule

// File: rtl/video_stream_gen.sv
// Raster test-pattern source: hsync/vsync/de timing plus an 8-bit pixel.
// Ports:
//   clk, rst             pixel clock, async active-low reset
//   en                   run enable; low freezes the raster
//   pattern_sel          0 ramp, 1 x-gradient, 2 checker, 3 constant
//   const_val            pixel value for the constant pattern
//   pixel_out, de        pixel and data enable (pixel is 0 in blanking)
//   hsync, vsync         sync pulses at SYNC_POL level
//   x_pos, y_pos         column/row of the pixel on pixel_out
//   frame_start          pulse with pixel (0,0)
//   line_end             pulse with the last active pixel of each line
// Every output is a register fed from counter state, one clock behind it.
module video_stream_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b1,
  parameter int XW       = cnt_w(H_ACTIVE),
  parameter int YW       = cnt_w(V_ACTIVE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [1:0]    pattern_sel,
  input  logic [7:0]    const_val,
  output logic [7:0]    pixel_out,
  output logic          de,
  output logic          hsync,
  output logic          vsync,
  output logic [XW-1:0] x_pos,
  output logic [YW-1:0] y_pos,
  output logic          frame_start,
  output logic          line_end
);

  localparam int H_TOTAL = total4(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = total4(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW      = cnt_w(H_TOTAL + 1);
  localparam int VW      = cnt_w(V_TOTAL + 1);

  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_LASTA  = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam bit            VLINE0   = (V_ACTIVE + V_FP == 0) && (V_SYNC > 0);

  logic [HW-1:0] w_h;
  logic [VW-1:0] w_v, w_v_next;
  logic          w_h_wrap, w_frame_wrap;

  raster_counter #(.H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL), .HW(HW), .VW(VW)) u_cnt (
    .i_clk        (clk),
    .i_rst_n      (rst),
    .i_en         (en),
    .o_h_cnt      (w_h),
    .o_v_cnt      (w_v),
    .o_h_wrap     (w_h_wrap),
    .o_frame_wrap (w_frame_wrap)
  );

  // r_origin: counters sit at (0,0). r_vline: current line is a vsync line.
  // Both are updated only at wrap points, so vsync edges land on h_cnt=0.
  logic       r_origin, r_vline;
  logic [1:0] r_pat;
  logic [7:0] r_const;

  logic       w_latch, w_act, w_hs, w_vnext_sync;
  logic [1:0] w_pat;
  logic [7:0] w_cval, w_x8, w_y8, w_pix;

  assign w_v_next     = w_frame_wrap ? '0 : w_v + VW'(1);
  assign w_vnext_sync = (w_v_next >= VS_START) && (w_v_next <= VS_END);
  assign w_act        = (w_h < H_ACT) && (w_v < V_ACT);
  assign w_hs         = (w_h >= HS_START) && (w_h <= HS_END);

  // Pixel (0,0) already uses the freshly latched selection.
  assign w_latch = en && r_origin;
  assign w_pat   = w_latch ? pattern_sel : r_pat;
  assign w_cval  = w_latch ? const_val : r_const;

  assign w_x8 = 8'(w_h);
  assign w_y8 = 8'(w_v);

  always_comb begin
    w_pix = 8'h00;
    case (w_pat)
      PAT_RAMP:  w_pix = w_x8 + w_y8 * 8'(H_ACTIVE);
      PAT_XGRAD: w_pix = w_x8;
      PAT_CHECK: w_pix = (w_x8[3] ^ w_y8[3]) ? 8'hFF : 8'h00;
      PAT_CONST: w_pix = w_cval;
      default:   w_pix = 8'h00;
    endcase
  end

  logic [7:0]    r_pix;
  logic          r_de, r_hs, r_vs, r_fs, r_le;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_origin <= 1'b1;
      r_vline  <= VLINE0;
      r_pat    <= PAT_RAMP;
      r_const  <= 8'h00;
      r_pix    <= 8'h00;
      r_de     <= 1'b0;
      r_fs     <= 1'b0;
      r_le     <= 1'b0;
      r_hs     <= ~SYNC_POL;
      r_vs     <= ~SYNC_POL;
      r_x      <= '0;
      r_y      <= '0;
    end else if (en) begin
      r_origin <= w_frame_wrap;
      if (w_h_wrap) r_vline <= w_vnext_sync;
      if (w_latch) begin
        r_pat   <= pattern_sel;
        r_const <= const_val;
      end
      r_de  <= w_act;
      r_fs  <= w_act && r_origin;
      r_le  <= w_act && (w_h == H_LASTA);
      r_pix <= w_act ? w_pix : 8'h00;
      r_hs  <= w_hs ? SYNC_POL : ~SYNC_POL;
      r_vs  <= r_vline ? SYNC_POL : ~SYNC_POL;
      if (w_act) begin
        r_x <= XW'(w_h);
        r_y <= YW'(w_v);
      end
    end else begin
      // Paused: syncs and position hold, data qualifiers drop.
      r_de  <= 1'b0;
      r_fs  <= 1'b0;
      r_le  <= 1'b0;
      r_pix <= 8'h00;
    end
  end

  assign pixel_out   = r_pix;
  assign de          = r_de;
  assign hsync       = r_hs;
  assign vsync       = r_vs;
  assign x_pos       = r_x;
  assign y_pos       = r_y;
  assign frame_start = r_fs;
  assign line_end    = r_le;

endmodule

// File: tb/tb_video_stream_gen.sv
// Bench for video_stream_gen: default-timing instance checked through a
// pixel scoreboard plus per-cycle timing checks; a second 20x12 instance
// checks the checkerboard pattern.
module tb_video_stream_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en;
  logic [1:0] pattern_sel;
  logic [7:0] const_val, pixel_out;
  logic       de, hsync, vsync, frame_start, line_end;
  logic [3:0] x_pos;
  logic [2:0] y_pos;

  video_stream_gen dut (
    .clk(clk), .rst(rst), .en(en), .pattern_sel(pattern_sel), .const_val(const_val),
    .pixel_out(pixel_out), .de(de), .hsync(hsync), .vsync(vsync),
    .x_pos(x_pos), .y_pos(y_pos), .frame_start(frame_start), .line_end(line_end)
  );

  logic       rst2, en2;
  logic [1:0] psel2;
  logic [7:0] cval2, pix2;
  logic       de2, hs2, vs2, fs2, le2;
  logic [4:0] x2;
  logic [3:0] y2;

  video_stream_gen #(.H_ACTIVE(20), .V_ACTIVE(12)) dut2 (
    .clk(clk), .rst(rst2), .en(en2), .pattern_sel(psel2), .const_val(cval2),
    .pixel_out(pix2), .de(de2), .hsync(hs2), .vsync(vs2),
    .x_pos(x2), .y_pos(y2), .frame_start(fs2), .line_end(le2)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] pix;
    logic [3:0] x;
    logic [2:0] y;
    logic       le;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  bit   mon_on = 1'b0;

  // Scoreboard: every de cycle of the default instance pops one expected pixel.
  always begin
    @(posedge clk);
    #1;
    if (mon_on && de === 1'b1) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL mon_unexpected: got pix=%0d at (%0d,%0d), want no pixel", pixel_out, x_pos, y_pos);
      end else begin
        mon_e = q.pop_front();
        if (pixel_out !== mon_e.pix || x_pos !== mon_e.x || y_pos !== mon_e.y || line_end !== mon_e.le) begin
          fails++;
          $display("FAIL mon_pixel: got pix=%0d x=%0d y=%0d le=%b, want pix=%0d x=%0d y=%0d le=%b",
                   pixel_out, x_pos, y_pos, line_end, mon_e.pix, mon_e.x, mon_e.y, mon_e.le);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push the first n active pixels of a default 10x5 frame.
  task automatic push_frame(input int pat, input logic [7:0] cv, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.x   = 4'(i % 10);
      e.y   = 3'(i / 10);
      e.pix = (pat == 3) ? cv : 8'(i);
      e.le  = ((i % 10) == 9);
      q.push_back(e);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; pattern_sel = 2'd0; const_val = 8'h00;
    #2;
    tests++;
    if ({de, frame_start, line_end, hsync, vsync} !== 5'b0 || pixel_out !== 8'h00) begin
      fails++;
      $display("FAIL reset_ctrl: got de/fs/le/hs/vs=%b%b%b%b%b pix=%0d, want 00000 pix=0",
               de, frame_start, line_end, hsync, vsync, pixel_out);
    end
    tests++;
    if (x_pos !== 4'd0 || y_pos !== 3'd0) begin
      fails++;
      $display("FAIL reset_pos: got (%0d,%0d), want (0,0)", x_pos, y_pos);
    end
    tick(); tick();
    tests++;
    if (de !== 1'b0 || hsync !== 1'b0) begin
      fails++;
      $display("FAIL reset_hold: got de=%b hs=%b, want 0 0", de, hsync);
    end
  endtask

  task automatic test_ramp_frame();
    logic [4:0] got, want;
    int h, v;
    push_frame(0, 8'h00, 50);
    mon_on = 1'b1;
    en = 1'b1;
    @(negedge clk) rst = 1'b1;
    for (int c = 0; c < 128; c++) begin
      tick();
      h = c % 16;
      v = c / 16;
      want[4] = (h < 10) && (v < 5);
      want[3] = (h >= 12) && (h <= 14);
      want[2] = (v == 6);
      want[1] = want[4] && (h == 9);
      want[0] = (c == 0);
      got = {de, hsync, vsync, line_end, frame_start};
      tests++;
      if (got !== want) begin
        fails++;
        $display("FAIL ramp_timing c=%0d: got de/hs/vs/le/fs=%b, want %b", c, got, want);
      end
    end
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL ramp_count: got %0d pixels left, want 0", q.size());
    end
  endtask

  task automatic test_pause();
    int  t = 0;
    int  fs_extra = 0;
    bit  paused = 1'b0;
    push_frame(0, 8'h00, 50);
    while (t < 135) begin
      tick();
      t++;
      if (t == 1) begin
        tests++;
        if (frame_start !== 1'b1) begin
          fails++;
          $display("FAIL pause_fs0: got fs=%b, want 1", frame_start);
        end
      end else if (frame_start === 1'b1) fs_extra++;
      if (!paused && de === 1'b1 && x_pos == 4'd3 && y_pos == 3'd2) begin
        en = 1'b0;
        for (int k = 0; k < 7; k++) begin
          tick();
          t++;
          tests++;
          if ({de, frame_start, line_end, hsync, vsync} !== 5'b0 || pixel_out !== 8'h00) begin
            fails++;
            $display("FAIL pause_hold k=%0d: got de/fs/le/hs/vs=%b%b%b%b%b pix=%0d, want 00000 pix=0",
                     k, de, frame_start, line_end, hsync, vsync, pixel_out);
          end
        end
        en = 1'b1;
        paused = 1'b1;
      end
    end
    tests++;
    if (!paused || fs_extra != 0 || q.size() != 0) begin
      fails++;
      $display("FAIL pause_frame: got paused=%0d extra_fs=%0d left=%0d, want 1 0 0", paused, fs_extra, q.size());
    end
  endtask

  task automatic test_pattern_change();
    push_frame(0, 8'h00, 50);
    for (int c = 0; c < 128; c++) begin
      tick();
      if (c == 0) begin
        tests++;
        if (frame_start !== 1'b1) begin
          fails++;
          $display("FAIL patchg_fs: got fs=%b after 135-clock frame, want 1", frame_start);
        end
      end
      if (c == 20) begin
        pattern_sel = 2'd3;
        const_val   = 8'hA5;
      end
    end
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL patchg_cur: got %0d pixels left, want 0", q.size());
    end
    push_frame(3, 8'hA5, 50);
    for (int c = 0; c < 128; c++) tick();
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL patchg_next: got %0d pixels left, want 0", q.size());
    end
  endtask

  task automatic test_async_reset();
    pattern_sel = 2'd0;
    push_frame(0, 8'h00, 38);
    for (int c = 0; c < 56; c++) tick();
    #3;
    rst = 1'b0;
    #1;
    tests++;
    if ({de, frame_start, line_end, hsync, vsync} !== 5'b0 || pixel_out !== 8'h00) begin
      fails++;
      $display("FAIL arst_ctrl: got de/fs/le/hs/vs=%b%b%b%b%b pix=%0d, want 00000 pix=0",
               de, frame_start, line_end, hsync, vsync, pixel_out);
    end
    tests++;
    if (x_pos !== 4'd0 || y_pos !== 3'd0 || q.size() != 0) begin
      fails++;
      $display("FAIL arst_pos: got (%0d,%0d) left=%0d, want (0,0) left=0", x_pos, y_pos, q.size());
    end
    tick(); tick();
    push_frame(0, 8'h00, 50);
    @(negedge clk) rst = 1'b1;
    for (int c = 0; c < 128; c++) begin
      tick();
      if (c == 0) begin
        tests++;
        if (frame_start !== 1'b1 || pixel_out !== 8'h00) begin
          fails++;
          $display("FAIL arst_restart: got fs=%b pix=%0d, want fs=1 pix=0", frame_start, pixel_out);
        end
      end
    end
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL arst_frame: got %0d pixels left, want 0", q.size());
    end
    mon_on = 1'b0;
  endtask

  task automatic test_checker();
    int hits = 0;
    logic [7:0] want;
    @(negedge clk) begin
      rst2 = 1'b1;
      en2  = 1'b1;
    end
    for (int c = 0; c < 390; c++) begin
      tick();
      if (de2 === 1'b1 && ((x2 == 5'd8 && y2 == 4'd0) || (x2 == 5'd8 && y2 == 4'd8) ||
                           (x2 == 5'd0 && y2 == 4'd8) || (x2 == 5'd19 && y2 == 4'd11))) begin
        // (8,0): 1^0, (8,8): 1^1, (0,8): 0^1, (19,11): 0^1 on bit 3
        want = (x2 == 5'd8 && y2 == 4'd8) ? 8'h00 : 8'hFF;
        hits++;
        tests++;
        if (pix2 !== want) begin
          fails++;
          $display("FAIL checker (%0d,%0d): got %h, want %h", x2, y2, pix2, want);
        end
      end
    end
    tests++;
    if (hits != 4) begin
      fails++;
      $display("FAIL checker_hits: got %0d, want 4", hits);
    end
  endtask

  initial begin
    rst2 = 1'b0; en2 = 1'b0; psel2 = 2'd2; cval2 = 8'h00;
    test_reset();
    test_ramp_frame();
    test_pause();
    test_pattern_change();
    test_async_reset();
    test_checker();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
